sm3_msg_expander: RTL and testbench
===================================

Name: sm3_msg_expander

Overview:
- SM3 message-expansion scheduler that sequences the P1 permutation datapath.
- Accepts one 512-bit block as 16 serial 32-bit words and streams out the 64 expansion pairs (W_j, W'_j), one per beat, j = 0..63.
- Feeds the compression-round controller.
- Word-serial with a 16-entry sliding window, so exactly one P1 evaluation per produced word.

Parameters:
- ROUNDS, 64, number of output beats per block; fixed by SM3, must be 64 (elaboration error otherwise).
- WORD_W, 32, word width; fixed, must be 32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active low
- soft_clr  input  1  synchronous abort; returns to IDLE, discards block
- in_valid  input  1  message word valid
- in_ready  output  1  expander can accept a word
- in_word  input  [0:31]  message word, bit 0 = MSB, big-endian order W0 first
- out_valid  output  1  expansion pair valid
- out_ready  input  1  consumer accepts pair
- out_w  output  [0:31]  W_j
- out_wp  output  [0:31]  W'_j = W_j ^ W_(j+4)
- out_idx  output  6  j
- out_last  output  1  high with j = 63
- busy  output  1  high in LOAD or EXPAND

Behaviour:
- Reset (rst_n low, async): state IDLE, window cleared to 0, counters 0. Outputs: in_ready=1, out_valid=0, out_w=0, out_wp=0, out_idx=0, out_last=0, busy=0.
- States: IDLE, LOAD, EXPAND.
- IDLE -> LOAD on the first accepted word (in_valid & in_ready).
- LOAD:
  - in_ready=1.
  - Each accepted word shifts into win[15]; win[k] <= win[k+1].
  - Load counter increments 0..15.
  - On the 16th accept -> EXPAND, idx=0.
  - in_valid low stalls without penalty.
- EXPAND:
  - in_ready=0, out_valid=1.
  - out_w = win[0]; out_wp = win[0]^win[4]; out_idx = idx.
  - Outputs are combinational from registered window and must hold stable while out_valid & !out_ready.
- On an accepted beat (out_valid & out_ready):
  - Window shifts left.
  - win[15] <= P1(win[0]^win[7]^rotl(win[13],15)) ^ rotl(win[3],7) ^ win[10].
  - idx increments.
- P1(x) = x ^ rotl(x,15) ^ rotl(x,23). rotl is rotate toward bit 0 (MSB).
- Shift-in values generated after W67 are don't-care but deterministic.
- Accepted beat with idx=63 -> IDLE. in_ready rises the next cycle.
- No in/out overlap between blocks.
- Latency:
  - 16th input accept at cycle t -> out_valid at t+1.
  - With out_ready held high: 64 consecutive beats, block turnaround 16+64 cycles.
- soft_clr:
  - Has priority over all handshakes in the same cycle.
  - Next state IDLE, counters 0, out_valid=0.
  - Window contents are not required to clear.
- Async reset mid-LOAD or mid-EXPAND: immediate return to reset values; partial block lost.
- in_valid during EXPAND is ignored (in_ready=0). out_ready outside EXPAND is ignored.

Optional Feature:
- Macro SM3_EXP_PERF_EN.
- Defined:
  - Adds output blk_cnt [15:0]: count of completed blocks (64th beat accepted).
  - Wraps 0xFFFF -> 0x0000.
  - Reset 0; not cleared by soft_clr.
  - Adds output stall_cnt [15:0]: cycles in EXPAND with out_ready=0, saturating at 0xFFFF.
- Undefined: neither port exists, no counter logic.

Decomposition:
- Package sm3_pkg:
  - typedef sm3_word_t (logic [0:31]).
  - enum sm3_exp_state_t {IDLE, LOAD, EXPAND}.
  - constants SM3_ROUNDS=64, SM3_MSG_WORDS=16.
  - functions rotl32(x,n) and p1(x).
- One natural sub-module: sm3_p1, combinational P1 on sm3_word_t, instantiated once on the feedback path.

Test Plan:
- "abc" padded block (61626380, 14x 00000000, 00000018), out_ready=1 -> idx0 out_w=61626380, out_wp=61626380; idx12 out_wp=9092e200; idx16 out_w=9092e200; out_last only at idx63; out_valid exactly 1 cycle after 16th accept.
- Same block, out_ready toggled with random 0/1 pattern -> identical 64-pair sequence; outputs stable across every stall; 64 beats only.
- in_valid gaps during LOAD (words 5 and 11 delayed 3 cycles) -> same outputs as the gap-free run; in_ready stays 1 throughout LOAD.
- soft_clr at idx 20 with out_ready=1 -> out_valid=0 next cycle, in_ready=1; a fresh "abc" block then reproduces idx0=61626380.
- rst_n pulsed low asynchronously mid-LOAD (after word 7) -> all outputs take reset values before the next clk edge; 16 new words required before any out_valid.
- SM3_EXP_PERF_EN defined, three back-to-back blocks with 10 stall cycles -> blk_cnt=3, stall_cnt=10; blk_cnt unchanged by soft_clr.

Source files
------------

// File: rtl/sm3_pkg.sv
// Shared types, constants and rotate/P1 helpers for the SM3 message expander.
package sm3_pkg;

  typedef logic [0:31] sm3_word_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND
  } sm3_exp_state_t;

  localparam int SM3_ROUNDS    = 64;
  localparam int SM3_MSG_WORDS = 16;

  // Bit 0 is the MSB, so rotating toward bit 0 is a numeric left rotate.
  function automatic sm3_word_t rotl32(input sm3_word_t x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic sm3_word_t p1(input sm3_word_t x);
    return x ^ rotl32(x, 5'd15) ^ rotl32(x, 5'd23);
  endfunction

endpackage

// File: rtl/sm3_msg_expander_if.sv
// Word-in / pair-out handshake bundle between the message source, the expander
// and the compression-round controller.
interface sm3_msg_expander_if;
  import sm3_pkg::*;

  logic       in_valid;
  logic       in_ready;
  sm3_word_t  in_word;
  logic       out_valid;
  logic       out_ready;
  sm3_word_t  out_w;
  sm3_word_t  out_wp;
  logic [5:0] out_idx;
  logic       out_last;

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_w, out_wp, out_idx, out_last
  );

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_w, out_wp, out_idx, out_last
  );

endinterface

// File: rtl/sm3_p1.sv
// Combinational SM3 P1 permutation on one word.
module sm3_p1
  import sm3_pkg::*;
(
  input  sm3_word_t x,
  output sm3_word_t y
);

  assign y = p1(x);

endmodule

// File: rtl/sm3_msg_expander.sv
// SM3 message-expansion scheduler: 16 serial words in, 64 (W_j, W'_j) pairs out.
// Optional block/stall counters are built when SM3_EXP_PERF_EN is defined.
//
// state  | meaning
// IDLE   | waiting for word 0 of a new block
// LOAD   | shifting message words 1..15 into the window
// EXPAND | presenting pair idx, one feedback word generated per accepted beat
module sm3_msg_expander
  import sm3_pkg::*;
#(
  parameter int ROUNDS = 64,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_clr,
  sm3_msg_expander_if.slave bus,
  output logic              busy
`ifdef SM3_EXP_PERF_EN
  ,
  output logic [15:0]       blk_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  if (ROUNDS != SM3_ROUNDS) begin : g_bad_rounds
    $error("sm3_msg_expander: ROUNDS must be 64");
  end
  if (WORD_W != 32) begin : g_bad_word_w
    $error("sm3_msg_expander: WORD_W must be 32");
  end

  localparam int LAST_IDX = ROUNDS - 1;

  sm3_exp_state_t state, state_nxt;
  sm3_word_t      win [SM3_MSG_WORDS];
  logic [3:0]     load_cnt;
  logic [5:0]     idx;
  logic           in_rdy, out_vld;
  logic           in_acc, out_acc, last_idx;
  sm3_word_t      p1_in, p1_out, fb_word, shift_word;

  assign last_idx = (idx == LAST_IDX[5:0]);
  assign in_acc   = in_rdy & bus.in_valid;
  assign out_acc  = out_vld & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        in_rdy = 1'b1;
        busy   = 1'b1;
        if (bus.in_valid && load_cnt == 4'd15) state_nxt = EXPAND;
      end
      EXPAND: begin
        out_vld = 1'b1;
        busy    = 1'b1;
        if (bus.out_ready && last_idx) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (soft_clr) state_nxt = IDLE;
  end

  // Window slot k holds W_(idx+k); the new slot 15 is W_(idx+16).
  assign p1_in = win[0] ^ win[7] ^ rotl32(win[13], 5'd15);

  sm3_p1 u_p1 (
    .x (p1_in),
    .y (p1_out)
  );

  assign fb_word    = p1_out ^ rotl32(win[3], 5'd7) ^ win[10];
  assign shift_word = in_rdy ? bus.in_word : fb_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SM3_MSG_WORDS; k++) win[k] <= '0;
      load_cnt <= '0;
      idx      <= '0;
    end else if (soft_clr) begin
      load_cnt <= '0;
      idx      <= '0;
    end else if (in_acc || out_acc) begin
      for (int k = 0; k < SM3_MSG_WORDS - 1; k++) win[k] <= win[k+1];
      win[SM3_MSG_WORDS-1] <= shift_word;
      if (in_acc) begin
        load_cnt <= load_cnt + 4'd1;
        idx      <= '0;
      end else begin
        idx <= idx + 6'd1;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_w     = out_vld ? win[0] : '0;
  assign bus.out_wp    = out_vld ? (win[0] ^ win[4]) : '0;
  assign bus.out_idx   = idx;
  assign bus.out_last  = out_vld & last_idx;

`ifdef SM3_EXP_PERF_EN
  // Both counters survive soft_clr; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_acc && last_idx && !soft_clr) blk_cnt <= blk_cnt + 16'd1;
      if (out_vld && !bus.out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sm3_msg_expander.sv
// Scoreboard bench for sm3_msg_expander: a reference W/W' schedule is queued per
// block and compared beat by beat as the expander hands out pairs.
module tb_sm3_msg_expander;

  typedef struct {
    logic [31:0] w;
    logic [31:0] wp;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic soft_clr = 1'b0;
  logic busy;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  logic [31:0] abc_blk [16];
  logic [31:0] rnd_blk [16];

  sm3_msg_expander_if bus ();

`ifdef SM3_EXP_PERF_EN
  logic [15:0] blk_cnt;
  logic [15:0] stall_cnt;
`endif

  sm3_msg_expander dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .soft_clr (soft_clr),
    .bus      (bus.slave),
    .busy     (busy)
`ifdef SM3_EXP_PERF_EN
    ,
    .blk_cnt  (blk_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] m_p1(input logic [31:0] x);
    return x ^ m_rotl(x, 15) ^ m_rotl(x, 23);
  endfunction

  task automatic push_expected(input logic [31:0] blk [16]);
    logic [31:0] w [68];
    exp_t e;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int j = 16; j < 68; j++)
      w[j] = m_p1(w[j-16] ^ w[j-9] ^ m_rotl(w[j-3], 15)) ^ m_rotl(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) begin
      e.w    = w[j];
      e.wp   = w[j] ^ w[j+4];
      e.idx  = 6'(j);
      e.last = (j == 63);
      exp_q.push_back(e);
    end
  endtask

  // rmode: 0 = out_ready high, 1 = random out_ready, 2 = exactly 10 stall cycles at beat 5
  task automatic run_block(input logic [31:0] blk [16], input int rmode, input bit gaps,
                           input int abort_at, input bit abc);
    int nw = 0, beats = 0, gap_cnt = 0, acc16 = -100, stall_left = 10;
    bit seen = 0, held = 0, rdy_ok = 1, stop = 0, aborted = 0;
    logic [31:0] hw = '0, hwp = '0;
    logic [5:0]  hidx = '0;
    exp_t e;
    push_expected(blk);
    for (int it = 0; it < 2000 && !stop; it++) begin
      @(negedge clk);
      cyc++;
      soft_clr = 1'b0;
      if (bus.out_valid) begin
        if (!seen) begin
          check("latency", 64'(cyc - acc16), 64'd1);
          seen = 1;
        end
        if (held) begin
          check("hold_pair", {bus.out_w, bus.out_wp}, {hw, hwp});
          check("hold_idx", 64'(bus.out_idx), 64'(hidx));
        end
        case (rmode)
          0: bus.out_ready = 1'b1;
          1: bus.out_ready = 1'($urandom_range(0, 1));
          default: begin
            if (beats == 5 && stall_left > 0) begin
              bus.out_ready = 1'b0;
              stall_left--;
            end else bus.out_ready = 1'b1;
          end
        endcase
        if (abort_at == int'(bus.out_idx)) begin
          soft_clr      = 1'b1;
          bus.out_ready = 1'b1;
          stop          = 1;
          aborted       = 1;
        end else if (bus.out_ready) begin
          if (exp_q.size() == 0) check("extra_beat", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            check("out_w", 64'(bus.out_w), 64'(e.w));
            check("out_wp", 64'(bus.out_wp), 64'(e.wp));
            check("out_idx", 64'(bus.out_idx), 64'(e.idx));
            check("out_last", 64'(bus.out_last), 64'(e.last));
            if (abc && e.idx == 6'd0) check("abc_w0", 64'(bus.out_w), 64'h61626380);
            if (abc && e.idx == 6'd0) check("abc_wp0", 64'(bus.out_wp), 64'h61626380);
            if (abc && e.idx == 6'd12) check("abc_wp12", 64'(bus.out_wp), 64'h9092e200);
            if (abc && e.idx == 6'd16) check("abc_w16", 64'(bus.out_w), 64'h9092e200);
          end
          beats++;
          held = 0;
          if (beats == 64) stop = 1;
        end else begin
          held = 1;
          hw   = bus.out_w;
          hwp  = bus.out_wp;
          hidx = bus.out_idx;
        end
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end

      bus.in_valid = 1'b0;
      if (busy && !bus.out_valid && !bus.in_ready) rdy_ok = 0;
      if (nw < 16 && !stop) begin
        if (gaps && (nw == 5 || nw == 11) && gap_cnt < 3) gap_cnt++;
        else begin
          bus.in_valid = 1'b1;
          bus.in_word  = blk[nw];
        end
        if (bus.in_valid && bus.in_ready) begin
          gap_cnt = 0;
          nw++;
          if (nw == 16) acc16 = cyc;
        end
      end else if (!stop && rmode == 1) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_word  = $urandom;
      end
    end

    if (!stop) check("timeout", 64'd0, 64'd1);
    @(negedge clk);
    cyc++;
    soft_clr     = 1'b0;
    bus.in_valid = 1'b0;
    check("end_out_valid", 64'(bus.out_valid), 64'd0);
    check("end_in_ready", 64'(bus.in_ready), 64'd1);
    if (aborted) begin
      check("abort_busy", 64'(busy), 64'd0);
      exp_q.delete();
    end
    if (gaps) check("load_in_ready", 64'(rdy_ok), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_w"}, 64'(bus.out_w), 64'd0);
    check({tag, "_out_wp"}, 64'(bus.out_wp), 64'd0);
    check({tag, "_out_idx"}, 64'(bus.out_idx), 64'd0);
    check({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    abc_blk[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) abc_blk[i] = 32'h0;
    abc_blk[15] = 32'h00000018;
    for (int i = 0; i < 16; i++) rnd_blk[i] = $urandom;
    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.out_ready = 1'b0;

    #1 check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_block(abc_blk, 0, 0, -1, 1);
    run_block(abc_blk, 1, 0, -1, 1);
    run_block(abc_blk, 0, 1, -1, 1);
    run_block(abc_blk, 0, 0, 20, 1);
    run_block(abc_blk, 0, 0, -1, 1);
    run_block(rnd_blk, 1, 1, -1, 0);

    // async reset after word 7 of a block
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_word  = abc_blk[i];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("midload_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_block(abc_blk, 0, 0, -1, 1);

`ifdef SM3_EXP_PERF_EN
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("perf_rst_blk", 64'(blk_cnt), 64'd0);
    check("perf_rst_stall", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(abc_blk, 2, 0, -1, 1);
    run_block(rnd_blk, 0, 0, -1, 0);
    run_block(abc_blk, 0, 0, -1, 1);
    check("perf_blk_cnt", 64'(blk_cnt), 64'd3);
    check("perf_stall_cnt", 64'(stall_cnt), 64'd10);
    @(negedge clk);
    soft_clr = 1'b1;
    @(negedge clk);
    soft_clr = 1'b0;
    check("perf_blk_after_clr", 64'(blk_cnt), 64'd3);
    check("perf_stall_after_clr", 64'(stall_cnt), 64'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
